// File: rtl/mem_writer_if.sv
// Stream-in / memory-write-port bundle for mem_writer.
// The writer uses the slave modport; the producer and memory side use master.
interface mem_writer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] mem_write_address;
    logic [DATA_WIDTH-1:0] mem_data_in;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_write_en, mem_write_address, mem_data_in
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_write_en, mem_write_address, mem_data_in
    );
endinterface

// File: rtl/mem_writer.sv
// Streaming write master: takes 'length' stream words and writes them at base_addr.. (mod 2^AW).
// Latency: word accepted at edge N is written at edge N+1; done pulses the cycle after DONE.
// Backpressure: s_ready is high only in WRITE; optional MEM_WRITER_CHECKSUM_EN adds an XOR checksum.
module mem_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    mem_writer_if.slave           bus,
    output logic                  busy,
    output logic                  done,
`ifdef MEM_WRITER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic [ADDR_WIDTH:0]   words_written
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  handshake;

    assign bus.s_ready = (state == S_WRITE);
    assign handshake   = bus.s_valid && (state == S_WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= S_IDLE;
            addr                  <= '0;
            remaining             <= '0;
            bus.mem_write_en      <= 1'b0;
            bus.mem_write_address <= '0;
            bus.mem_data_in       <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            words_written         <= '0;
`ifdef MEM_WRITER_CHECKSUM_EN
            checksum              <= '0;
`endif
        end else begin
            done             <= 1'b0;
            bus.mem_write_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        words_written <= '0;
                        busy          <= 1'b1;
`ifdef MEM_WRITER_CHECKSUM_EN
                        checksum      <= '0;
`endif
                        if (length != '0) begin
                            addr      <= base_addr;
                            remaining <= length;
                            state     <= S_WRITE;
                        end else begin
                            state     <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    if (handshake) begin
                        bus.mem_write_en      <= 1'b1;
                        bus.mem_write_address <= addr;
                        bus.mem_data_in       <= bus.s_data;
                        addr                  <= addr + ADDR_WIDTH'(1);
                        remaining             <= remaining - (ADDR_WIDTH+1)'(1);
                        words_written         <= words_written + (ADDR_WIDTH+1)'(1);
`ifdef MEM_WRITER_CHECKSUM_EN
                        checksum              <= checksum ^ bus.s_data;
`endif
                        if (remaining == (ADDR_WIDTH+1)'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // The last write is in flight this cycle, so done lands after it.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer: transfer-level model checked every cycle plus literal pins.
module tb_mem_writer;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW:0]   words_written;
`ifdef MEM_WRITER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
`ifdef MEM_WRITER_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .words_written (words_written)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory as seen by whatever the DUT writes
    logic [DW-1:0] tmem [16];
    initial foreach (tmem[i]) tmem[i] = '0;
    always @(posedge clk) if (bus.mem_write_en) tmem[bus.mem_write_address] <= bus.mem_data_in;

    // Transfer-level model: is a transfer open, how many words left, where the next one goes
    bit          armed = 0;
    bit          m_active, m_finishing;
    int          m_left, m_next, m_count;
    bit          m_we, m_done;
    int          m_waddr, m_wdata, m_cks;

    always @(posedge clk) begin
        if (rst) begin
            armed = 1; m_active = 0; m_finishing = 0;
            m_left = 0; m_next = 0; m_count = 0;
            m_we = 0; m_done = 0; m_cks = 0;
        end else begin
            m_we = 0;
            m_done = 0;
            if (m_finishing) begin
                m_done = 1;
                m_finishing = 0;
            end else if (m_active) begin
                if (bus.s_valid) begin
                    m_we = 1;
                    m_waddr = m_next;
                    m_wdata = bus.s_data;
                    m_next = (m_next + 1) % 16;
                    m_left--;
                    m_count++;
                    m_cks = m_cks ^ bus.s_data;
                    if (m_left == 0) begin
                        m_active = 0;
                        m_finishing = 1;
                    end
                end
            end else if (start) begin
                m_count = 0;
                m_cks = 0;
                if (length > 0) begin
                    m_active = 1;
                    m_left = length;
                    m_next = base_addr;
                end else begin
                    m_finishing = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("s_ready", bus.s_ready, m_active);
            check("mem_write_en", bus.mem_write_en, m_we);
            if (m_we) begin
                check("mem_write_address", bus.mem_write_address, m_waddr);
                check("mem_data_in", bus.mem_data_in, m_wdata);
            end
            check("busy", busy, m_active || m_finishing);
            check("done", done, m_done);
            check("words_written", words_written, m_count);
`ifdef MEM_WRITER_CHECKSUM_EN
            check("checksum", checksum, m_cks);
`endif
        end
    end

    // Called just after a negedge; returns just after the next one
    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
        start = 1'b1; base_addr = b; length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input bit v, input logic [DW-1:0] d);
        bus.s_valid = v; bus.s_data = d;
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with start and s_valid active
        start = 1'b1; base_addr = 4'd3; length = 5'd3;
        bus.s_valid = 1'b1; bus.s_data = 8'hAA;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_mem_write_en", bus.mem_write_en, 0);
        check("rst_mem_write_address", bus.mem_write_address, 0);
        check("rst_mem_data_in", bus.mem_data_in, 0);
        check("rst_done", done, 0);
        check("rst_words_written", words_written, 0);
        rst = 1'b0; start = 1'b0; bus.s_valid = 1'b0;
        @(negedge clk);

        // Continuous burst
        do_start(4'd2, 5'd4);
        send(1, 8'h21); send(1, 8'h22); send(1, 8'h23); send(1, 8'h24);
        bus.s_valid = 1'b0;
        check("burst_done_pre", done, 0);
        @(negedge clk);
        check("burst_done", done, 1);
        check("burst_busy", busy, 0);
        check("burst_words", words_written, 4);
        check("burst_mem2", tmem[2], 8'h21);
        check("burst_mem3", tmem[3], 8'h22);
        check("burst_mem4", tmem[4], 8'h23);
        check("burst_mem5", tmem[5], 8'h24);
`ifdef MEM_WRITER_CHECKSUM_EN
        check("burst_checksum", checksum, 8'h04);
`endif

        // Gapped stream
        do_start(4'd6, 5'd3);
`ifdef MEM_WRITER_CHECKSUM_EN
        check("checksum_cleared", checksum, 8'h00);
`endif
        send(1, 8'h31); send(0, 8'hEE); send(0, 8'hEE);
        send(1, 8'h32); send(0, 8'hEE); send(1, 8'h33);
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("gap_done", done, 1);
        check("gap_words", words_written, 3);
        check("gap_mem6", tmem[6], 8'h31);
        check("gap_mem7", tmem[7], 8'h32);
        check("gap_mem8", tmem[8], 8'h33);

        // Wrap with an ignored start mid-transfer
        do_start(4'd14, 5'd4);
        send(1, 8'h41);
        start = 1'b1; base_addr = 4'd0; length = 5'd2;
        send(1, 8'h42);
        start = 1'b0;
        send(1, 8'h43); send(1, 8'h44);
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("wrap_done", done, 1);
        check("wrap_words", words_written, 4);
        check("wrap_mem14", tmem[14], 8'h41);
        check("wrap_mem15", tmem[15], 8'h42);
        check("wrap_mem0", tmem[0], 8'h43);
        check("wrap_mem1", tmem[1], 8'h44);
        check("wrap_mem2_kept", tmem[2], 8'h21);

        // Length zero: done two cycles after start
        do_start(4'd3, 5'd0);
        check("len0_busy", busy, 1);
        check("len0_done_early", done, 0);
        @(negedge clk);
        check("len0_done", done, 1);
        check("len0_words", words_written, 0);
        check("len0_mem3_kept", tmem[3], 8'h22);

        // Reset after 2 of 5 words, then a clean transfer
        do_start(4'd10, 5'd5);
        send(1, 8'h51); send(1, 8'h52);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.s_valid = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_s_ready", bus.s_ready, 0);
        check("midrst_mem_write_en", bus.mem_write_en, 0);
        check("midrst_words", words_written, 0);
        check("midrst_mem10", tmem[10], 8'h51);
        do_start(4'd8, 5'd2);
        send(1, 8'h61); send(1, 8'h62);
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("after_rst_done", done, 1);
        check("after_rst_words", words_written, 2);
        check("after_rst_mem8", tmem[8], 8'h61);
        check("after_rst_mem9", tmem[9], 8'h62);

        // Start in the same cycle done is high
        do_start(4'd12, 5'd1);
        send(1, 8'h71);
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("b2b_first_done", done, 1);
        do_start(4'd13, 5'd1);
        check("b2b_s_ready", bus.s_ready, 1);
        send(1, 8'h72);
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_done", done, 1);
        check("b2b_mem12", tmem[12], 8'h71);
        check("b2b_mem13", tmem[13], 8'h72);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
